// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake and data bundle for the nibble-serial adder controller.
// The producer drives operands on the in_* side; the consumer takes
// results from the out_* side. The controller uses the slave modport.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller.
// A single 4-bit ripple slice is stepped across WIDTH-bit operands, least
// significant nibble first, one nibble per clock. The carry between slices
// lives in a register. The handshake flags are registered copies of the
// state, so they never depend combinationally on in_valid or out_ready.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] sliceIdx_q;
  logic             cout_q;
  logic             ovf_q;
  logic             inReady_q;
  logic             outValid_q;
  logic             busy_q;

  logic [3:0]       sliceA;
  logic [3:0]       sliceB;
  logic [4:0]       sliceRes;
  logic             msbCarryIn;
  logic             sliceOvf;

  // Combinational 4-bit slice: picks the current nibble of each operand,
  // adds it with the stored carry, and derives the signed-overflow term
  // (carry into the slice's top bit XOR carry out), which only matters
  // when the slice being processed is the most significant one.
  always_comb begin
    sliceA     = opA_q[{sliceIdx_q, 2'b00} +: 4];
    sliceB     = opB_q[{sliceIdx_q, 2'b00} +: 4];
    sliceRes   = {1'b0, sliceA} + {1'b0, sliceB} + {4'b0000, carry_q};
    msbCarryIn = sliceA[3] ^ sliceB[3] ^ sliceRes[3];
    sliceOvf   = msbCarryIn ^ sliceRes[4];
  end

  // Controller FSM: accepts operands in IDLE, walks the slice index through
  // every nibble in ADD, then holds the result in DONE until the consumer
  // takes it. Handshake flags are updated together with the state so they
  // always reflect the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      sliceIdx_q <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            opA_q      <= bus.a;
            opB_q      <= bus.b;
            carry_q    <= bus.cin;
            sliceIdx_q <= '0;
            sum_q      <= '0;
            state_q    <= ADD;
            inReady_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ADD: begin
          sum_q[{sliceIdx_q, 2'b00} +: 4] <= sliceRes[3:0];
          carry_q <= sliceRes[4];
          if (sliceIdx_q == LAST_IDX) begin
            cout_q     <= sliceRes[4];
            ovf_q      <= sliceOvf;
            state_q    <= DONE;
            outValid_q <= 1'b1;
          end else begin
            sliceIdx_q <= sliceIdx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            inReady_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
          inReady_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
// Each scenario task drives its own stimulus and compares outputs against
// hand-computed values one time unit after the rising edge.
module tb_nibble_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand set for a single accept edge; caller ensures IDLE.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'hDEAD;
    bus.b        = 16'hBEEF;
    bus.cin      = 1'b0;
  endtask

  // Waits the four slice edges that follow an accept.
  task automatic waitSlices();
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  // Hands the held result back with a one-cycle out_ready pulse.
  task automatic releaseResult();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.cin      = 1'($urandom);
      bus.in_valid = i[0];
      @(posedge clk); #1;
    end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if ({bus.sum, bus.cout, bus.ovf} !== 18'h0) begin failures++; $display("[TB] FAIL rst_result: got sum=%h cout=%b ovf=%b expected all 0", bus.sum, bus.cout, bus.ovf); end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_no_start: got busy=%b in_ready=%b expected busy=0 in_ready=1", bus.busy, bus.in_ready); end
  endtask

  task automatic test_basic_add();
    launch(16'h1234, 16'h4321, 1'b0);
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_accept: got in_ready=%b busy=%b expected 0/1", bus.in_ready, bus.busy); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== (k == 4)) begin failures++; $display("[TB] FAIL basic_latency_T%0d: got out_valid=%b expected %b", k, bus.out_valid, (k == 4)); end
      if (k == 1) begin
        checks++; if (bus.sum !== 16'h0005) begin failures++; $display("[TB] FAIL basic_partial_T1: got %h expected 0005", bus.sum); end
      end
      if (k == 2) begin
        checks++; if (bus.sum !== 16'h0055) begin failures++; $display("[TB] FAIL basic_partial_T2: got %h expected 0055", bus.sum); end
      end
    end
    checks++; if (bus.sum !== 16'h5555) begin failures++; $display("[TB] FAIL basic_sum: got %h expected 5555", bus.sum); end
    checks++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin failures++; $display("[TB] FAIL basic_flags: got cout=%b ovf=%b expected 0/0", bus.cout, bus.ovf); end
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_done_flags: got in_ready=%b busy=%b expected 0/1", bus.in_ready, bus.busy); end
    releaseResult();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_return: got in_ready=%b out_valid=%b busy=%b expected 1/0/0", bus.in_ready, bus.out_valid, bus.busy); end
  endtask

  task automatic test_carry_ripple();
    launch(16'hFFFF, 16'h0000, 1'b1);
    waitSlices();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL ripple_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0000) begin failures++; $display("[TB] FAIL ripple_sum: got %h expected 0000", bus.sum); end
    checks++; if (bus.cout !== 1'b1 || bus.ovf !== 1'b0) begin failures++; $display("[TB] FAIL ripple_flags: got cout=%b ovf=%b expected 1/0", bus.cout, bus.ovf); end
    releaseResult();
  endtask

  task automatic test_overflow();
    launch(16'h7FFF, 16'h0001, 1'b0);
    waitSlices();
    checks++; if (bus.sum !== 16'h8000) begin failures++; $display("[TB] FAIL ovf_pos_sum: got %h expected 8000", bus.sum); end
    checks++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_pos_flags: got cout=%b ovf=%b expected 0/1", bus.cout, bus.ovf); end
    releaseResult();
    launch(16'h8000, 16'h8000, 1'b0);
    waitSlices();
    checks++; if (bus.sum !== 16'h0000) begin failures++; $display("[TB] FAIL ovf_neg_sum: got %h expected 0000", bus.sum); end
    checks++; if (bus.cout !== 1'b1 || bus.ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_neg_flags: got cout=%b ovf=%b expected 1/1", bus.cout, bus.ovf); end
    releaseResult();
  endtask

  task automatic test_backpressure();
    launch(16'h00FF, 16'h0001, 1'b0);
    waitSlices();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid: got %b expected 1", bus.out_valid); end
    bus.a        = 16'h0F0F;
    bus.b        = 16'h0101;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (bus.sum !== 16'h0100 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_%0d: got sum=%h cout=%b ovf=%b expected 0100/0/0", k, bus.sum, bus.cout, bus.ovf); end
      checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_stall_%0d: got in_ready=%b out_valid=%b expected 0/1", k, bus.in_ready, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_return: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL bp_second_accept: got in_ready=%b busy=%b expected 0/1", bus.in_ready, bus.busy); end
    waitSlices();
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 16'h1010) begin failures++; $display("[TB] FAIL bp_second_sum: got valid=%b sum=%h expected 1/1010", bus.out_valid, bus.sum); end
    releaseResult();
  endtask

  task automatic test_back_to_back();
    int firstHit;
    int secondHit;
    int hits;
    firstHit  = -1;
    secondHit = -1;
    hits      = 0;
    bus.a         = 16'h0001;
    bus.b         = 16'h0001;
    bus.cin       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        hits++;
        if (firstHit < 0) firstHit = cyc;
        else if (secondHit < 0) secondHit = cyc;
        checks++; if (bus.sum !== 16'h0002) begin failures++; $display("[TB] FAIL b2b_sum_c%0d: got %h expected 0002", cyc, bus.sum); end
      end
    end
    bus.in_valid  = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    checks++; if (firstHit != 4) begin failures++; $display("[TB] FAIL b2b_first: got cycle %0d expected 4", firstHit); end
    checks++; if (secondHit - firstHit != 6) begin failures++; $display("[TB] FAIL b2b_period: got %0d expected 6", secondHit - firstHit); end
    checks++; if (hits != 3) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 3", hits); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle: got in_ready=%b expected 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_add();
    int pulses;
    pulses = 0;
    launch(16'hABCD, 16'h1111, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++; if (bus.sum !== 16'h00DE) begin failures++; $display("[TB] FAIL mid_partial: got %h expected 00DE", bus.sum); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.sum, bus.cout, bus.ovf, bus.out_valid, bus.busy} !== 20'h0) begin failures++; $display("[TB] FAIL mid_outputs: got sum=%h cout=%b ovf=%b valid=%b busy=%b expected all 0", bus.sum, bus.cout, bus.ovf, bus.out_valid, bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL mid_no_result: got %0d valid cycles expected 0", pulses); end
    launch(16'h0001, 16'h0002, 1'b1);
    waitSlices();
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0004 || bus.cout !== 1'b0) begin failures++; $display("[TB] FAIL mid_after: got valid=%b sum=%h cout=%b expected 1/0004/0", bus.out_valid, bus.sum, bus.cout); end
    releaseResult();
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_add();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
